// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode boundary: the fetch entry triple and
// architectural constants used by the fetch queue and its neighbours.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_add4;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x fetch_entry_t, one synchronous
// write port and one combinational read port. Contents are never reset.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  fetch_entry_t         wdata,
  input  logic [AW-1:0]        raddr,
  output fetch_entry_t         rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction FIFO between fetch and decode; a redirect (flush) empties it in
// one cycle. Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass fetch straight to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_pc_add4,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc_add4,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          occupied, push, pop;
  fetch_entry_t  wdata, rdata, head;

  assign occupied = (count_q != '0);
  // Ready depends on registered occupancy only, so a full queue refuses even when decode pops.
  assign in_ready = (count_q != (AW+1)'(DEPTH));
  assign wdata    = '{instr: in_instr, pc: in_pc, pc_add4: in_pc_add4};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass, direct;
  assign bypass    = !occupied && !flush;
  assign direct    = bypass && in_valid && out_ready;
  assign out_valid = occupied || (bypass && in_valid);
  assign head      = occupied ? rdata : wdata;
  assign push      = in_valid && in_ready && !flush && !direct;
`else
  assign out_valid = occupied;
  assign head      = rdata;
  assign push      = in_valid && in_ready && !flush;
`endif

  // Only stored entries are popped; a bypassed entry never touches the pointers.
  assign pop = occupied && out_ready && !flush;

  assign out_instr   = out_valid ? head.instr   : NOP_INSTR;
  assign out_pc      = out_valid ? head.pc      : '0;
  assign out_pc_add4 = out_valid ? head.pc_add4 : '0;
  assign count       = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus predicts queue contents from the
// FIFO rules, a negedge monitor compares the DUT outputs against them.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_instr = '0, in_pc = '0, in_pc_add4 = '0;
  logic          in_ready, out_valid;
  logic [31:0]   out_instr, out_pc, out_pc_add4;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_pc_add4(in_pc_add4),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_add4(out_pc_add4), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  fetch_entry_t exp_q[$];
  fetch_entry_t cur, pend_e;
  bit pend_push = 0, pend_clr = 0, direct_now = 0, chk_en = 0;
  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic next_entry();
    cur.pc      = cur.pc + 32'd4;
    cur.pc_add4 = cur.pc + 32'd4;
    cur.instr   = $urandom;
  endtask

  // One clock cycle: commit last cycle's predicted effect, then drive new inputs.
  task automatic cycle(input bit iv, input bit ordy, input bit fl, input bit rst);
    int  mcnt;
    bit  direct, acc;
    @(posedge clk);
    if (pend_clr) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_e);
    #1;
    in_valid   = iv;
    in_instr   = cur.instr;
    in_pc      = cur.pc;
    in_pc_add4 = cur.pc_add4;
    out_ready  = ordy;
    flush      = fl;
    reset      = rst;
    mcnt   = exp_q.size();
    direct = BYP && !fl && mcnt == 0 && iv && ordy;
    acc    = iv && !fl && !rst && mcnt != DEPTH && !direct;
    pend_push  = acc;
    pend_e     = cur;
    pend_clr   = fl || rst;
    direct_now = direct;
    if (direct) exp_q.push_back(cur);
    if (acc || (direct && !rst)) next_entry();
  endtask

  always @(negedge clk) begin
    int           ecnt;
    bit           ev;
    fetch_entry_t e;
    if (chk_en) begin
      ecnt = exp_q.size() - (direct_now ? 1 : 0);
      chk("count", 96'(count), 96'(ecnt));
      chk("in_ready", 96'(in_ready), 96'(ecnt != DEPTH));
      ev = (ecnt != 0) || (BYP && !flush && in_valid);
      chk("out_valid", 96'(out_valid), 96'(ev));
      if (!ev) e = '0;
      else if (exp_q.size() != 0) e = exp_q[0];
      else e = '{instr: in_instr, pc: in_pc, pc_add4: in_pc_add4};
      chk("out_entry", {out_instr, out_pc, out_pc_add4}, e);
      if (ev && out_ready && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    cur.pc      = RESET_PC;
    cur.pc_add4 = RESET_PC + 32'd4;
    cur.instr   = $urandom;

    cycle(0, 0, 0, 1);
    chk_en = 1;
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0);

    // Fill, press against full, then drain in order.
    repeat (4) cycle(1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    repeat (4) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);

    // Steady stream, pointers wrap several times.
    repeat (20) cycle(1, 1, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);

    // Full queue flushed while fetch presents a new entry.
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    repeat (3) cycle(0, 1, 0, 0);

    // Reset with three entries held, then restart from RESET_PC.
    repeat (3) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    cur.pc = RESET_PC; cur.pc_add4 = RESET_PC + 32'd4; cur.instr = $urandom;
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);

    // Single entry into an empty queue with decode ready.
    cur.instr = 32'h2408_0001;
    cycle(1, 1, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);

    // Randomized traffic with occasional redirects and resets.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    repeat (6) cycle(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction FIFO between the fetch stage and the decode stage.
- Each entry holds the triple produced by fetch: instruction, pc and pc_add4.
- Decouples decode stalls from fetch: fetch stalls only when the queue is full.
- A branch/jump redirect empties the queue in one cycle.

Parameters:
DEPTH, 4, number of entries; power of two, 2..16
AW, $clog2(DEPTH), pointer width (derived, not overridable)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
flush  input  1  redirect; discard all entries and any push this cycle
in_valid  input  1  fetch presents a valid entry
in_instr  input  32  fetched instruction word
in_pc  input  32  pc of in_instr
in_pc_add4  input  32  in_pc + 4 as computed by fetch
in_ready  output  1  queue can accept; fetch uses !in_ready as its stall
out_valid  output  1  head entry valid for decode
out_instr  output  32  head instruction; 32'h0 (NOP) when !out_valid
out_pc  output  32  head pc; 0 when !out_valid
out_pc_add4  output  32  head pc_add4; 0 when !out_valid
out_ready  input  1  decode consumes head this cycle
count  output  AW+1  current occupancy 0..DEPTH

Behaviour:
- Reset (synchronous, active-high, reset on clk): wr_ptr=0, rd_ptr=0, count=0; out_valid=0, in_ready=1, out_* = 0. Storage contents need not be reset.
- Handshake:
  - push = in_valid && in_ready && !flush.
  - pop = out_valid && out_ready && !flush.
- Ready rule: in_ready = (count != DEPTH). It is registered-state only and never depends on out_ready in the same cycle. So there is no push while full, even if a pop occurs.
- Push: write entry at wr_ptr; wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: rd_ptr increments modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
- Outputs: out_valid = (count != 0). out_* present the entry at rd_ptr combinationally from storage, forced to 0 when !out_valid.
- Latency (bypass disabled): an entry pushed at edge N is visible on out_* during the cycle after edge N. Minimum latency is 1 cycle.
- Order: strict FIFO; entries are never reordered or duplicated.
- Flush:
  - Takes priority over push and pop.
  - At the next edge: wr_ptr=rd_ptr=0, count=0.
  - During the flush cycle, out_valid is still driven from current state, but decode must treat it as killed, and no pop is counted.
- Reset versus flush: reset takes priority over flush.
- Empty with out_ready=1: no effect, and count does not underflow.
- Full with in_valid=1: entry is not accepted. Fetch holds it via stall and re-presents the same pc.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- When defined, and count==0 with !flush:
  - out_valid = in_valid, and out_* = in_* combinationally.
  - If out_ready=1, the entry is consumed directly. There is no write and count stays 0.
  - If out_ready=0 and in_ready=1, the entry is pushed normally.
- When undefined: behaviour is exactly as in Behaviour, with minimum latency of 1 cycle.

Decomposition:
- Shared package fetch_pkg:
  - typedef struct packed {logic[31:0] instr, pc, pc_add4;} fetch_entry_t.
  - localparam NOP_INSTR = 32'h0000_0000.
  - localparam RESET_PC = 32'h0040_0000.
- One sub-module, fetch_queue_mem: a DEPTH x fetch_entry_t register array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata). Pointer and count control stays in fetch_queue.

Test Plan:
1. Reset, then idle → count=0, out_valid=0, in_ready=1, out_instr=0.
2. Push pc 0x00400000..0x0040000C with out_ready=0 → count=4, in_ready=0. A 5th in_valid with pc 0x00400010 is not accepted. Then out_ready=1 for 4 cycles → pops in pc order with correct pc_add4; count returns to 0.
3. Steady stream with in_valid=out_ready=1 for 20 cycles → count stays at 1 (0 with bypass), pointers wrap past 3, and output pc increases by 4 each cycle.
4. Full queue, flush=1 with in_valid=1 in the same cycle → next cycle count=0, out_valid=0, and the flushed-cycle entry never appears.
5. Reset asserted with count=3 → next cycle count=0, in_ready=1; subsequent push of pc 0x00400000 is output first.
6. FETCH_QUEUE_BYPASS_EN build: empty queue, in_valid=1, out_ready=1, in_instr=0x24080001 → out_instr=0x24080001 in the same cycle, count stays 0. Non-bypass build → output appears one cycle later.
